id_ex_hazard_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage RV32I core, with the load-use hazard detector and branch-flush bubble logic attached.
- Captures decoded operands, register indices and control from ID and presents them to EX.
- Its EX_RS1/EX_RS2 feed the forwarding unit's RS1/RS2.
- Drives PCWrite/IFIDWrite/IFIDFlush back to IF and ID, and keeps saturating stall/flush event counters.

---
 rtl/riscv_pipe_pkg.sv | 35 +++
 rtl/hazard_detect.sv | 28 ++
 rtl/id_ex_hazard_reg.sv | 129 ++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// ============================================================================
//  Module : riscv_pipe_pkg
//  Brief  : Shared pipeline control-word layout for the 5-stage RV32I core.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pipe_pkg;

  localparam int CTRL_W = 8;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_BRANCH   = 7;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // Field order mirrors the bit positions above (MSB first).
  typedef struct packed {
    logic       branch;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
//  Module : hazard_detect
//  Brief  : Combinational load-use hazard detection between EX and ID.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_detect
  import riscv_pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use
);

  // Both source fields are compared for every format; false stalls are harmless.
  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_hazard_reg.sv
// ============================================================================
//  Module : id_ex_hazard_reg
//  Brief  : ID/EX pipeline register with load-use stall, branch flush and
//           saturating stall/flush event counters.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_hazard_reg
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_Valid,
  input  logic [XLEN-1:0]   ID_PC,
  input  logic [XLEN-1:0]   ID_RD1,
  input  logic [XLEN-1:0]   ID_RD2,
  input  logic [XLEN-1:0]   ID_Imm,
  input  logic [4:0]        ID_RS1,
  input  logic [4:0]        ID_RS2,
  input  logic [4:0]        ID_RD,
  input  logic [2:0]        ID_Funct3,
  input  logic              ID_Funct7b5,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic              ExtStall,
  input  logic              BranchTaken,
  output logic              EX_Valid,
  output logic [XLEN-1:0]   EX_PC,
  output logic [XLEN-1:0]   EX_RD1,
  output logic [XLEN-1:0]   EX_RD2,
  output logic [XLEN-1:0]   EX_Imm,
  output logic [4:0]        EX_RS1,
  output logic [4:0]        EX_RS2,
  output logic [4:0]        EX_RD,
  output logic [2:0]        EX_Funct3,
  output logic              EX_Funct7b5,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDFlush,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  logic load_use;
  logic do_flush;
  logic do_stall;
  logic do_bubble;

  hazard_detect u_hazard_detect (
    .ex_valid    (EX_Valid),
    .ex_mem_read (EX_Ctrl[CTRL_MEMREAD]),
    .ex_rd       (EX_RD),
    .id_valid    (ID_Valid),
    .id_rs1      (ID_RS1),
    .id_rs2      (ID_RS2),
    .load_use    (load_use)
  );

  // A taken branch outranks load-use; ExtStall masks both.
  always_comb begin
    do_flush  = !ExtStall && BranchTaken;
    do_stall  = !ExtStall && !BranchTaken && load_use;
    do_bubble = do_flush || do_stall;
    PCWrite   = !ExtStall && !do_stall;
    IFIDWrite = !ExtStall && !do_stall;
    IFIDFlush = do_flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_Valid    <= 1'b0;
      EX_PC       <= '0;
      EX_RD1      <= '0;
      EX_RD2      <= '0;
      EX_Imm      <= '0;
      EX_RS1      <= '0;
      EX_RS2      <= '0;
      EX_RD       <= '0;
      EX_Funct3   <= '0;
      EX_Funct7b5 <= 1'b0;
      EX_Ctrl     <= CTRL_BUBBLE;
    end else if (!ExtStall) begin
      if (do_bubble) begin
        EX_Valid    <= 1'b0;
        EX_PC       <= '0;
        EX_RD1      <= '0;
        EX_RD2      <= '0;
        EX_Imm      <= '0;
        EX_RS1      <= '0;
        EX_RS2      <= '0;
        EX_RD       <= '0;
        EX_Funct3   <= '0;
        EX_Funct7b5 <= 1'b0;
        EX_Ctrl     <= CTRL_BUBBLE;
      end else begin
        EX_Valid    <= ID_Valid;
        EX_PC       <= ID_PC;
        EX_RD1      <= ID_RD1;
        EX_RD2      <= ID_RD2;
        EX_Imm      <= ID_Imm;
        EX_RS1      <= ID_RS1;
        EX_RS2      <= ID_RS2;
        EX_RD       <= ID_RD;
        EX_Funct3   <= ID_Funct3;
        EX_Funct7b5 <= ID_Funct7b5;
        EX_Ctrl     <= ID_Valid ? ID_Ctrl : CTRL_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (do_stall && (StallCount != {CNT_W{1'b1}}))
        StallCount <= StallCount + 1'b1;
      if (do_flush && (FlushCount != {CNT_W{1'b1}}))
        FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
// ============================================================================
//  Module : tb_id_ex_hazard_reg
//  Brief  : Self-checking bench for id_ex_hazard_reg against a behavioural model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_hazard_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ID_Valid = 1'b0;
  logic [XLEN-1:0]  ID_PC = '0, ID_RD1 = '0, ID_RD2 = '0, ID_Imm = '0;
  logic [4:0]       ID_RS1 = '0, ID_RS2 = '0, ID_RD = '0;
  logic [2:0]       ID_Funct3 = '0;
  logic             ID_Funct7b5 = 1'b0;
  logic [7:0]       ID_Ctrl = '0;
  logic             ExtStall = 1'b0, BranchTaken = 1'b0;
  logic             EX_Valid;
  logic [XLEN-1:0]  EX_PC, EX_RD1, EX_RD2, EX_Imm;
  logic [4:0]       EX_RS1, EX_RS2, EX_RD;
  logic [2:0]       EX_Funct3;
  logic             EX_Funct7b5;
  logic [7:0]       EX_Ctrl;
  logic             PCWrite, IFIDWrite, IFIDFlush;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_hazard_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ID_Valid(ID_Valid), .ID_PC(ID_PC),
    .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_Imm(ID_Imm), .ID_RS1(ID_RS1),
    .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_Funct3(ID_Funct3),
    .ID_Funct7b5(ID_Funct7b5), .ID_Ctrl(ID_Ctrl), .ExtStall(ExtStall),
    .BranchTaken(BranchTaken), .EX_Valid(EX_Valid), .EX_PC(EX_PC),
    .EX_RD1(EX_RD1), .EX_RD2(EX_RD2), .EX_Imm(EX_Imm), .EX_RS1(EX_RS1),
    .EX_RS2(EX_RS2), .EX_RD(EX_RD), .EX_Funct3(EX_Funct3),
    .EX_Funct7b5(EX_Funct7b5), .EX_Ctrl(EX_Ctrl), .PCWrite(PCWrite),
    .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .StallCount(StallCount),
    .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the instruction EX should hold, plus event tallies.
  typedef struct {
    bit        valid;
    bit [31:0] pc, rd1, rd2, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [2:0]  f3;
    bit        f7;
    bit [7:0]  ctrl;
  } instr_t;

  instr_t m_ex;
  int     m_stalls = 0;
  int     m_flushes = 0;

  function automatic bit model_load_use();
    return m_ex.valid && m_ex.ctrl[1] && m_ex.rd != 0 && ID_Valid &&
           (m_ex.rd == ID_RS1 || m_ex.rd == ID_RS2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex      = '{default: 0};
      m_stalls  = 0;
      m_flushes = 0;
    end else if (!ExtStall) begin
      if (BranchTaken) begin
        m_ex = '{default: 0};
        if (m_flushes < CMAX) m_flushes++;
      end else if (model_load_use()) begin
        m_ex = '{default: 0};
        if (m_stalls < CMAX) m_stalls++;
      end else begin
        m_ex.valid = ID_Valid;
        m_ex.pc  = ID_PC;  m_ex.rd1 = ID_RD1; m_ex.rd2 = ID_RD2; m_ex.imm = ID_Imm;
        m_ex.rs1 = ID_RS1; m_ex.rs2 = ID_RS2; m_ex.rd  = ID_RD;
        m_ex.f3  = ID_Funct3; m_ex.f7 = ID_Funct7b5;
        m_ex.ctrl = ID_Valid ? ID_Ctrl : 8'h00;
      end
    end
  end

  // Every-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    bit lu, exp_pcw;
    lu = model_load_use();
    exp_pcw = ExtStall ? 1'b0 : (BranchTaken ? 1'b1 : !lu);
    chk("m_valid", EX_Valid, m_ex.valid);
    chk("m_pc",    EX_PC,    m_ex.pc);
    chk("m_rd1",   EX_RD1,   m_ex.rd1);
    chk("m_rd2",   EX_RD2,   m_ex.rd2);
    chk("m_imm",   EX_Imm,   m_ex.imm);
    chk("m_rs1",   EX_RS1,   m_ex.rs1);
    chk("m_rs2",   EX_RS2,   m_ex.rs2);
    chk("m_rd",    EX_RD,    m_ex.rd);
    chk("m_f3",    EX_Funct3, m_ex.f3);
    chk("m_f7",    EX_Funct7b5, m_ex.f7);
    chk("m_ctrl",  EX_Ctrl,  m_ex.ctrl);
    chk("m_pcwrite",  PCWrite,   exp_pcw);
    chk("m_ifidwrite", IFIDWrite, exp_pcw);
    chk("m_ifidflush", IFIDFlush, !ExtStall && BranchTaken);
    chk("m_stallcnt", StallCount, m_stalls);
    chk("m_flushcnt", FlushCount, m_flushes);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input bit [31:0] pc, input bit [4:0] rs1,
                        input bit [4:0] rs2, input bit [4:0] rd, input bit [7:0] ctrl);
    ID_Valid = v; ID_PC = pc; ID_RD1 = pc ^ 32'hA5A5_0000; ID_RD2 = pc + 32'd7;
    ID_Imm = ~pc; ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd;
    ID_Funct3 = pc[4:2]; ID_Funct7b5 = pc[2]; ID_Ctrl = ctrl;
  endtask

  initial begin
    #12;
    chk("rst_valid", EX_Valid, 1'b0);
    chk("rst_pc", EX_PC, 32'h0);
    chk("rst_pcwrite", PCWrite, 1'b1);
    chk("rst_ifidwrite", IFIDWrite, 1'b1);
    chk("rst_ifidflush", IFIDFlush, 1'b0);
    chk("rst_stallcnt", StallCount, 8'h00);
    cyc();
    rst_n = 1'b1;

    // Normal load
    set_id(1, 32'h100, 5, 0, 3, 8'h01);
    #1 chk("norm_pcwrite", PCWrite, 1'b1);
    cyc();
    chk("norm_pc", EX_PC, 32'h100);
    chk("norm_rs1", EX_RS1, 5'd5);
    chk("norm_valid", EX_Valid, 1'b1);

    // Load-use: lw x7 then consumer on rs2
    set_id(1, 32'h104, 1, 2, 7, 8'h0B);
    cyc();
    set_id(1, 32'h108, 3, 7, 9, 8'h01);
    #1 chk("lu_pcwrite", PCWrite, 1'b0);
    chk("lu_ifidwrite", IFIDWrite, 1'b0);
    cyc();
    chk("lu_valid", EX_Valid, 1'b0);
    chk("lu_ctrl", EX_Ctrl, 8'h00);
    chk("lu_stallcnt", StallCount, 8'd1);
    #1 chk("lu_release_pcwrite", PCWrite, 1'b1);
    cyc();
    chk("lu_rs2_loaded", EX_RS2, 5'd7);
    chk("lu_valid_loaded", EX_Valid, 1'b1);

    // lw to x0 never stalls
    set_id(1, 32'h10C, 1, 2, 0, 8'h0B);
    cyc();
    set_id(1, 32'h110, 0, 0, 4, 8'h01);
    #1 chk("x0_pcwrite", PCWrite, 1'b1);
    cyc();
    // non-load producer never stalls
    set_id(1, 32'h114, 1, 2, 7, 8'h01);
    cyc();
    set_id(1, 32'h118, 7, 3, 4, 8'h01);
    #1 chk("alu_pcwrite", PCWrite, 1'b1);
    cyc();
    chk("alu_stallcnt", StallCount, 8'd1);

    // Branch flush beats load-use
    set_id(1, 32'h11C, 1, 2, 7, 8'h0B);
    cyc();
    set_id(1, 32'h120, 7, 0, 4, 8'h01);
    BranchTaken = 1'b1;
    #1 chk("br_ifidflush", IFIDFlush, 1'b1);
    chk("br_pcwrite", PCWrite, 1'b1);
    cyc();
    BranchTaken = 1'b0;
    chk("br_valid", EX_Valid, 1'b0);
    chk("br_flushcnt", FlushCount, 8'd1);
    chk("br_stallcnt", StallCount, 8'd1);

    // ExtStall holds everything for 3 cycles, then the flush lands once
    set_id(1, 32'h200, 2, 3, 4, 8'h11);
    cyc();
    ExtStall = 1'b1; BranchTaken = 1'b1;
    set_id(1, 32'h204, 5, 6, 8, 8'h01);
    for (int i = 0; i < 3; i++) begin
      #1 chk("xs_pcwrite", PCWrite, 1'b0);
      chk("xs_ifidflush", IFIDFlush, 1'b0);
      cyc();
      chk("xs_pc_hold", EX_PC, 32'h200);
      chk("xs_flushcnt", FlushCount, 8'd1);
    end
    ExtStall = 1'b0;
    #1 chk("xs_rel_flush", IFIDFlush, 1'b1);
    cyc();
    BranchTaken = 1'b0;
    chk("xs_rel_flushcnt", FlushCount, 8'd2);
    chk("xs_rel_valid", EX_Valid, 1'b0);
    cyc();
    chk("xs_once", FlushCount, 8'd2);

    // Asynchronous reset in the middle of a stall
    set_id(1, 32'h300, 1, 2, 7, 8'h0B);
    cyc();
    set_id(1, 32'h304, 7, 7, 4, 8'h01);
    #1 chk("ar_pcwrite_pre", PCWrite, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("ar_valid", EX_Valid, 1'b0);
    chk("ar_pc", EX_PC, 32'h0);
    chk("ar_stallcnt", StallCount, 8'h00);
    chk("ar_flushcnt", FlushCount, 8'h00);
    chk("ar_pcwrite", PCWrite, 1'b1);
    cyc();
    rst_n = 1'b1;

    // Saturation: lw x7 reading x7 stalls every other cycle
    set_id(1, 32'h400, 7, 7, 7, 8'h0B);
    for (int i = 0; i < 2 * (CMAX + 5); i++) cyc();
    chk("sat_stallcnt", StallCount, 8'hFF);
    cyc();
    cyc();
    chk("sat_hold", StallCount, 8'hFF);

    set_id(0, 0, 0, 0, 0, 0);
    cyc();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
